// File: rtl/enc_quad_ctrl_multi_pkg.sv
// Shared register map, status layout and step classification for enc_quad_ctrl_multi.
// Index capture logic is only built when ENC_INDEX_EN is defined.
package enc_quad_ctrl_multi_pkg;

  localparam logic [3:0] ADDR_MAIN     = 4'h0;
  localparam logic [3:0] ADDR_ENC_CTRL = 4'h2;
  localparam logic [3:0] OFF_ENC_LOAD  = 4'h4;
  localparam logic [3:0] OFF_ENC_STAT  = 4'h5;
  localparam logic [3:0] OFF_ENC_CHAN  = 4'h3;

  localparam int ST_OVF     = 0;
  localparam int ST_UDF     = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_DIR     = 3;
  localparam int ST_IDX_LSB = 4;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ERR
  } step_e;

  function automatic logic [31:0] midrange(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/enc_quad_ctrl_multi_if.sv
// Register-bus bundle between the register file and enc_quad_ctrl_multi.
// reg_index_data only exists when ENC_INDEX_EN is defined.
interface enc_quad_ctrl_multi_if;

  logic [3:0]  reg_raddr_chan;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic [31:0] reg_preload;
  logic [31:0] reg_quad_data;
  logic [31:0] reg_status;
`ifdef ENC_INDEX_EN
  logic [31:0] reg_index_data;

  modport master (output reg_raddr_chan, reg_waddr, reg_wdata, reg_wen,
                  input  reg_preload, reg_quad_data, reg_status, reg_index_data);
  modport slave  (input  reg_raddr_chan, reg_waddr, reg_wdata, reg_wen,
                  output reg_preload, reg_quad_data, reg_status, reg_index_data);
`else
  modport master (output reg_raddr_chan, reg_waddr, reg_wdata, reg_wen,
                  input  reg_preload, reg_quad_data, reg_status);
  modport slave  (input  reg_raddr_chan, reg_waddr, reg_wdata, reg_wen,
                  output reg_preload, reg_quad_data, reg_status);
`endif

endinterface

// File: rtl/enc_quad_ctrl_multi_line_filter.sv
// Two-flop synchroniser followed by a DEPTH-sample debounce; the output only
// flips once every sample in the window agrees on the new level.
module enc_line_filter #(
  parameter int DEPTH = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic i_raw,
  output logic o_filt
);

  logic             r_meta;
  logic [DEPTH-1:0] r_hist;
  logic             r_filt;

  // r_hist[0] is the second synchroniser stage and also the newest debounce sample.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_hist <= '0;
      r_filt <= 1'b0;
    end else begin
      r_meta    <= i_raw;
      r_hist[0] <= r_meta;
      for (int i = 1; i < DEPTH; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
      if (&r_hist) begin
        r_filt <= 1'b1;
      end else if (~|r_hist) begin
        r_filt <= 1'b0;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/enc_quad_ctrl_multi.sv
// N-channel quadrature decoder with preload, sticky flags, read mux and feedback count.
// Define ENC_INDEX_EN to add index-pulse position capture per channel.
module enc_quad_ctrl_multi
  import enc_quad_ctrl_multi_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNT_WIDTH   = 24,
  parameter int FILT_BITS     = 2,
  parameter int IDX_FILT_BITS = 3
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] enc_a,
  input  logic [NUM_CHANNELS-1:0] enc_b,
`ifdef ENC_INDEX_EN
  input  logic [NUM_CHANNELS-1:0] enc_i,
`endif
  enc_quad_ctrl_multi_if.slave    bus,
  output logic [3:0]              fb_chan,
  output logic [COUNT_WIDTH-1:0]  fb_count,
  output logic [NUM_CHANNELS-1:0] enc_dir
);

  localparam logic [COUNT_WIDTH-1:0] MID = COUNT_WIDTH'(midrange(COUNT_WIDTH));
  localparam logic [4:0]             NCH = 5'(NUM_CHANNELS);

  logic                   w_load_hit;
  logic                   w_clr_hit;
  logic                   w_fb_hit;
  logic [3:0]             w_wchan;
  logic [COUNT_WIDTH-1:0] w_count   [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] w_preload [NUM_CHANNELS];
  logic [31:0]            w_status  [NUM_CHANNELS];
`ifdef ENC_INDEX_EN
  logic [31:0]            w_idx_word [NUM_CHANNELS];
`endif
  logic [COUNT_WIDTH-1:0] w_fb_sel;
  logic [3:0]             r_fb_chan;
  logic [COUNT_WIDTH-1:0] r_fb_count;
  logic                   w_unused_bits;

  assign w_wchan    = bus.reg_waddr[7:4];
  assign w_load_hit = bus.reg_wen && (bus.reg_waddr[15:12] == ADDR_MAIN)
                      && (bus.reg_waddr[3:0] == OFF_ENC_LOAD);
  assign w_clr_hit  = bus.reg_wen && (bus.reg_waddr[15:12] == ADDR_MAIN)
                      && (bus.reg_waddr[3:0] == OFF_ENC_STAT);
  assign w_fb_hit   = bus.reg_wen && (bus.reg_waddr[15:12] == ADDR_ENC_CTRL)
                      && (bus.reg_waddr[7:4] == OFF_ENC_CHAN);
  assign w_unused_bits = ^{bus.reg_waddr[11:8], bus.reg_wdata[31:COUNT_WIDTH]};

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
    logic                   w_a;
    logic                   w_b;
    logic                   w_load;
    logic [2:0]             w_clr;
    step_e                  w_step;
    logic [1:0]             r_ab_prev;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_preload;
    logic                   r_dir;
    logic                   r_ovf;
    logic                   r_udf;
    logic                   r_err;
    logic [31:0]            w_status_c;

    enc_line_filter #(.DEPTH(FILT_BITS)) u_filt_a (
      .sysclk(sysclk), .reset(reset), .i_raw(enc_a[k]), .o_filt(w_a));
    enc_line_filter #(.DEPTH(FILT_BITS)) u_filt_b (
      .sysclk(sysclk), .reset(reset), .i_raw(enc_b[k]), .o_filt(w_b));

    assign w_load = w_load_hit && (w_wchan == 4'(k));
    assign w_clr  = (w_clr_hit && (w_wchan == 4'(k))) ? bus.reg_wdata[2:0] : 3'b000;

    always_comb begin
      w_step = STEP_NONE;
      if ((w_a != r_ab_prev[1]) && (w_b != r_ab_prev[0])) begin
        w_step = STEP_ERR;
      end else if ((w_a != r_ab_prev[1]) || (w_b != r_ab_prev[0])) begin
        w_step = (w_a ^ r_ab_prev[0]) ? STEP_UP : STEP_DOWN;
      end
    end

    // A preload swallows a coinciding step entirely; flag set beats clear.
    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        r_ab_prev <= 2'b00;
        r_count   <= MID;
        r_preload <= MID;
        r_dir     <= 1'b0;
        r_ovf     <= 1'b0;
        r_udf     <= 1'b0;
        r_err     <= 1'b0;
      end else begin
        r_ab_prev <= {w_a, w_b};
        if (w_load) begin
          r_preload <= bus.reg_wdata[COUNT_WIDTH-1:0];
          r_count   <= bus.reg_wdata[COUNT_WIDTH-1:0];
        end else if (w_step == STEP_UP) begin
          r_count <= r_count + COUNT_WIDTH'(1);
          r_dir   <= 1'b1;
        end else if (w_step == STEP_DOWN) begin
          r_count <= r_count - COUNT_WIDTH'(1);
          r_dir   <= 1'b0;
        end
        r_ovf <= (r_ovf && !w_clr[ST_OVF]) || (!w_load && (w_step == STEP_UP) && (&r_count));
        r_udf <= (r_udf && !w_clr[ST_UDF]) || (!w_load && (w_step == STEP_DOWN) && (r_count == '0));
        r_err <= (r_err && !w_clr[ST_ERR]) || (w_step == STEP_ERR);
      end
    end

`ifdef ENC_INDEX_EN
    logic                 w_i;
    logic                 r_i_prev;
    logic [COUNT_WIDTH:0] r_idx_data;
    logic [3:0]           r_idx_cnt;
    logic [31:0]          w_idx_word_c;

    enc_line_filter #(.DEPTH(IDX_FILT_BITS)) u_filt_i (
      .sysclk(sysclk), .reset(reset), .i_raw(enc_i[k]), .o_filt(w_i));

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        r_i_prev   <= 1'b0;
        r_idx_data <= '0;
        r_idx_cnt  <= 4'd0;
      end else begin
        r_i_prev <= w_i;
        if (w_i && !r_i_prev) begin
          r_idx_data <= {r_dir, r_count};
          r_idx_cnt  <= r_idx_cnt + 4'd1;
        end
      end
    end

    always_comb begin
      w_idx_word_c                  = '0;
      w_idx_word_c[COUNT_WIDTH:0]   = r_idx_data;
      w_idx_word_c[31:28]           = r_idx_cnt;
    end
    assign w_idx_word[k] = w_idx_word_c;
`endif

    always_comb begin
      w_status_c         = '0;
      w_status_c[ST_OVF] = r_ovf;
      w_status_c[ST_UDF] = r_udf;
      w_status_c[ST_ERR] = r_err;
      w_status_c[ST_DIR] = r_dir;
`ifdef ENC_INDEX_EN
      w_status_c[ST_IDX_LSB +: 4] = r_idx_cnt;
`endif
    end

    assign w_count[k]   = r_count;
    assign w_preload[k] = r_preload;
    assign w_status[k]  = w_status_c;
    assign enc_dir[k]   = r_dir;
  end

  // Unmatched channel numbers fall through to the all-zero defaults.
  always_comb begin
    bus.reg_preload   = '0;
    bus.reg_quad_data = '0;
    bus.reg_status    = '0;
`ifdef ENC_INDEX_EN
    bus.reg_index_data = '0;
`endif
    w_fb_sel = MID;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (bus.reg_raddr_chan == 4'(k)) begin
        bus.reg_preload   = 32'(w_preload[k]);
        bus.reg_quad_data = 32'(w_count[k]);
        bus.reg_status    = w_status[k];
`ifdef ENC_INDEX_EN
        bus.reg_index_data = w_idx_word[k];
`endif
      end
      if (r_fb_chan == 4'(k)) begin
        w_fb_sel = w_count[k];
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_fb_chan  <= 4'd0;
      r_fb_count <= MID;
    end else begin
      if (w_fb_hit && ({1'b0, bus.reg_wdata[3:0]} < NCH)) begin
        r_fb_chan <= bus.reg_wdata[3:0];
      end
      r_fb_count <= w_fb_sel;
    end
  end

  assign fb_chan  = r_fb_chan;
  assign fb_count = r_fb_count;

endmodule

// File: tb/tb_enc_quad_ctrl_multi.sv
// Randomised bench for enc_quad_ctrl_multi against a phase-index quadrature model.
// Index capture checks are compiled in only when ENC_INDEX_EN is defined.
`timescale 1ns/1ps
module tb_enc_quad_ctrl_multi;
  import enc_quad_ctrl_multi_pkg::*;

  localparam int          NCH  = 4;
  localparam int          CW   = 24;
  localparam int unsigned MASK = 32'h00FF_FFFF;
  localparam int unsigned MID  = 32'h0080_0000;

  logic            sysclk = 1'b0;
  logic            reset  = 1'b1;
  logic [NCH-1:0]  encA   = '0;
  logic [NCH-1:0]  encB   = '0;
`ifdef ENC_INDEX_EN
  logic [NCH-1:0]  encI   = '0;
`endif
  logic [3:0]      fbChan;
  logic [CW-1:0]   fbCount;
  logic [NCH-1:0]  encDir;

  enc_quad_ctrl_multi_if bus();

  enc_quad_ctrl_multi #(
    .NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .FILT_BITS(2), .IDX_FILT_BITS(3)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .enc_a(encA),
    .enc_b(encB),
`ifdef ENC_INDEX_EN
    .enc_i(encI),
`endif
    .bus(bus),
    .fb_chan(fbChan),
    .fb_count(fbCount),
    .enc_dir(encDir)
  );

  always #5 sysclk = ~sysclk;

  int unsigned expCount [NCH];
  int unsigned expPre   [NCH];
  bit          expOvf   [NCH];
  bit          expUdf   [NCH];
  bit          expErr   [NCH];
  bit          expDir   [NCH];
  int          phase    [NCH];
  int unsigned idxCnt   [NCH];
  int unsigned idxData  [NCH];
  int          checkCount = 0;
  int          passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Phase index 0..3 walks 00,10,11,01 on {A,B}; the index difference classifies the move.
  task automatic modelMove(input int ch, input int newIdx);
    int delta;
    delta = (newIdx - phase[ch] + 4) % 4;
    if (delta == 1) begin
      if (expCount[ch] == MASK) expOvf[ch] = 1'b1;
      expCount[ch] = (expCount[ch] + 1) & MASK;
      expDir[ch]   = 1'b1;
    end else if (delta == 3) begin
      if (expCount[ch] == 0) expUdf[ch] = 1'b1;
      expCount[ch] = (expCount[ch] + MASK) & MASK;
      expDir[ch]   = 1'b0;
    end else if (delta == 2) begin
      expErr[ch] = 1'b1;
    end
    phase[ch] = newIdx;
  endtask

  task automatic driveLines(input int ch, input int idx);
    encA[ch] = (idx == 1) || (idx == 2);
    encB[ch] = (idx == 2) || (idx == 3);
  endtask

  task automatic applyStimulus(input int ch, input int newIdx);
    @(negedge sysclk);
    modelMove(ch, newIdx);
    driveLines(ch, newIdx);
    repeat (10) @(negedge sysclk);
  endtask

  task automatic writeReg(input logic [15:0] addr, input logic [31:0] data);
    @(negedge sysclk);
    bus.reg_waddr = addr;
    bus.reg_wdata = data;
    bus.reg_wen   = 1'b1;
    @(negedge sysclk);
    bus.reg_wen   = 1'b0;
  endtask

  task automatic preloadChan(input int ch, input int unsigned value);
    writeReg({ADDR_MAIN, 4'h0, 4'(ch), OFF_ENC_LOAD}, value);
    if (ch < NCH) begin
      expCount[ch] = value & MASK;
      expPre[ch]   = value & MASK;
    end
  endtask

  task automatic clearStatus(input int ch, input logic [2:0] bits);
    writeReg({ADDR_MAIN, 4'h0, 4'(ch), OFF_ENC_STAT}, {29'd0, bits});
    if (bits[0]) expOvf[ch] = 1'b0;
    if (bits[1]) expUdf[ch] = 1'b0;
    if (bits[2]) expErr[ch] = 1'b0;
  endtask

  task automatic checkChannel(input int ch);
    logic [31:0] expStatus;
    @(negedge sysclk);
    bus.reg_raddr_chan = 4'(ch);
    #1;
    expStatus = {24'd0, 4'd0, expDir[ch], expErr[ch], expUdf[ch], expOvf[ch]};
`ifdef ENC_INDEX_EN
    expStatus[7:4] = 4'(idxCnt[ch]);
    checkOutput($sformatf("idx%0d", ch), bus.reg_index_data,
                (idxCnt[ch] << 28) | idxData[ch]);
`endif
    checkOutput($sformatf("cnt%0d", ch), bus.reg_quad_data, expCount[ch]);
    checkOutput($sformatf("pre%0d", ch), bus.reg_preload, expPre[ch]);
    checkOutput($sformatf("stat%0d", ch), bus.reg_status, expStatus);
    checkOutput($sformatf("dir%0d", ch), {31'd0, encDir[ch]}, {31'd0, expDir[ch]});
  endtask

  task automatic glitchA(input int ch);
    @(negedge sysclk);
    encA[ch] = ~encA[ch];
    @(negedge sysclk);
    encA[ch] = ~encA[ch];
    repeat (10) @(negedge sysclk);
  endtask

`ifdef ENC_INDEX_EN
  task automatic indexPulse(input int ch);
    @(negedge sysclk);
    idxData[ch] = ({31'd0, expDir[ch]} << CW) | expCount[ch];
    idxCnt[ch]  = (idxCnt[ch] + 1) & 4'hF;
    encI[ch] = 1'b1;
    repeat (10) @(negedge sysclk);
    encI[ch] = 1'b0;
    repeat (10) @(negedge sysclk);
  endtask
`endif

  initial begin
    int ch;
    int op;
    int unsigned val;
    bus.reg_raddr_chan = 4'd0;
    bus.reg_waddr      = 16'd0;
    bus.reg_wdata      = 32'd0;
    bus.reg_wen        = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      expCount[k] = MID; expPre[k] = MID; expOvf[k] = 0; expUdf[k] = 0;
      expErr[k] = 0; expDir[k] = 0; phase[k] = 0; idxCnt[k] = 0; idxData[k] = 0;
    end
    repeat (3) @(negedge sysclk);
    reset = 1'b0;

    $display("[TB] reset state");
    for (int k = 0; k < NCH; k++) checkChannel(k);
    checkOutput("fbChanRst", {28'd0, fbChan}, 32'd0);
    checkOutput("fbCountRst", {8'd0, fbCount}, MID);
    @(negedge sysclk);
    bus.reg_raddr_chan = 4'd9;
    #1;
    checkOutput("cntOutOfRange", bus.reg_quad_data, 32'd0);
    checkOutput("statOutOfRange", bus.reg_status, 32'd0);

    $display("[TB] forward and reverse stepping on channel 2");
    for (int i = 0; i < 8; i++) applyStimulus(2, (phase[2] + 1) % 4);
    checkChannel(2);
    for (int i = 0; i < 3; i++) applyStimulus(2, (phase[2] + 3) % 4);
    checkChannel(2);

    $display("[TB] wrap flags on channel 1");
    preloadChan(1, 32'h00FF_FFFF);
    applyStimulus(1, (phase[1] + 1) % 4);
    checkChannel(1);
    clearStatus(1, 3'b001);
    checkChannel(1);
    preloadChan(1, 32'h0000_0000);
    applyStimulus(1, (phase[1] + 3) % 4);
    checkChannel(1);

    $display("[TB] double toggle and glitch on channel 0");
    applyStimulus(0, (phase[0] + 2) % 4);
    checkChannel(0);
    glitchA(0);
    checkChannel(0);

    $display("[TB] preload coincident with a step on channel 3");
    @(negedge sysclk);
    phase[3] = (phase[3] + 1) % 4;
    driveLines(3, phase[3]);
    repeat (3) @(negedge sysclk);
    preloadChan(3, 32'h0012_3456);
    repeat (10) @(negedge sysclk);
    checkChannel(3);

    preloadChan(9, 32'h0000_0055);
    for (int k = 0; k < NCH; k++) checkChannel(k);

    $display("[TB] feedback channel select");
    writeReg({ADDR_ENC_CTRL, 4'h0, OFF_ENC_CHAN, 4'h0}, 32'd2);
    checkOutput("fbChanSet", {28'd0, fbChan}, 32'd2);
    checkOutput("fbCountOld", {8'd0, fbCount}, expCount[0]);
    @(negedge sysclk);
    checkOutput("fbCountNew", {8'd0, fbCount}, expCount[2]);
    writeReg({ADDR_ENC_CTRL, 4'h0, OFF_ENC_CHAN, 4'h0}, 32'd7);
    @(negedge sysclk);
    checkOutput("fbChanHold", {28'd0, fbChan}, 32'd2);
    applyStimulus(2, (phase[2] + 1) % 4);
    checkOutput("fbCountTrack", {8'd0, fbCount}, expCount[2]);

`ifdef ENC_INDEX_EN
    $display("[TB] index capture");
    preloadChan(0, 32'h0080_0010);
    indexPulse(0);
    checkChannel(0);
    for (int i = 0; i < 16; i++) indexPulse(0);
    checkChannel(0);
`endif

    $display("[TB] randomised operations");
    for (int i = 0; i < 40; i++) begin
      ch = $urandom_range(0, NCH - 1);
      op = $urandom_range(0, 5);
      case (op)
        0: applyStimulus(ch, (phase[ch] + 1) % 4);
        1: applyStimulus(ch, (phase[ch] + 3) % 4);
        2: applyStimulus(ch, (phase[ch] + 2) % 4);
        3: glitchA(ch);
        4: begin
          val = $urandom & MASK;
          if ($urandom_range(0, 2) == 0) val = MASK;
          else if ($urandom_range(0, 2) == 0) val = 0;
          preloadChan(ch, val);
        end
        default: clearStatus(ch, 3'($urandom_range(0, 7)));
      endcase
      checkChannel(ch);
    end
    for (int k = 0; k < NCH; k++) checkChannel(k);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
